// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer
//   Row/frame scheduler for the 3-byte-per-pixel LED receive datapath.
//   Each PWM pass: AL422 read reset, shift every row (display previous row
//   while the next one shifts), latch, blank, then step pwm_value.
//
// Ports
//   in_clk, in_nrst   clock, asynchronous active-low reset
//   enable            run request (level); a row in progress always completes
//   pwm_cntr_strobe   datapath phase-0 strobe (checked only)
//   alrst_strobe      datapath phase-1 strobe (checked only)
//   led_clk           datapath phase-2 strobe; the following cycle is phase 0
//   pwm_value         8-bit threshold to the datapath comparator
//   row_addr          panel row address (row currently displayed)
//   lat               panel latch, one-cycle pulse
//   oe_n              panel output enable, active-low
//   al_rrst_n         AL422 read reset, active-low
//   al_re_n           AL422 read enable, active-low
//   frame_start       one-cycle pulse on the first cycle of each read reset
//   proto_err         sticky flag, set when a strobe arrives out of phase
module led_scan_sequencer #(
  parameter int COLS         = 64,
  parameter int LEAD         = 2,
  parameter int ROWS         = 16,
  parameter int ROW_W        = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int PWM_MAX      = 254
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  input  logic             enable,
  input  logic             pwm_cntr_strobe,
  input  logic             alrst_strobe,
  input  logic             led_clk,
  output logic [7:0]       pwm_value,
  output logic [ROW_W-1:0] row_addr,
  output logic             lat,
  output logic             oe_n,
  output logic             al_rrst_n,
  output logic             al_re_n,
  output logic             frame_start,
  output logic             proto_err
);

  localparam int CNT_W = $clog2(COLS + LEAD + 1);

  typedef enum logic [2:0] {IDLE, RRST, ALIGN, SHIFT, LATCH, BLANK} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] shift_row_q, shift_row_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [2:0]       blank_cnt_q, blank_cnt_d;
  logic             valid_q, valid_d;
  logic             first_q;
  logic             proto_q, proto_d;
  logic [7:0]       pwm_q, pwm_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic blank_last;
  logic cols_done;

  assign blank_last = (blank_cnt_q == 3'(BLANK_CYCLES - 1));
  assign cols_done  = (col_cnt_q == CNT_W'(COLS + LEAD - 1));

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q     <= IDLE;
      shift_row_q <= '0;
      col_cnt_q   <= '0;
      blank_cnt_q <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      proto_q     <= 1'b0;
      pwm_q       <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_row_q <= shift_row_d;
      col_cnt_q   <= col_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      valid_q     <= valid_d;
      // High on the first cycle spent in any state.
      first_q     <= (state_d != state_q);
      proto_q     <= proto_d;
      pwm_q       <= pwm_d;
      row_q       <= row_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_row_d = shift_row_q;
    col_cnt_d   = col_cnt_q;
    blank_cnt_d = blank_cnt_q;
    valid_d     = valid_q;
    pwm_d       = pwm_q;
    row_d       = row_q;
    lat         = 1'b0;
    oe_n        = 1'b1;
    al_rrst_n   = 1'b1;
    al_re_n     = 1'b1;
    frame_start = 1'b0;

    proto_d = proto_q | (alrst_strobe & led_clk) |
              ((state_q == SHIFT) & first_q & ~pwm_cntr_strobe);

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enable && led_clk) state_d = RRST;
      end
      RRST: begin
        al_rrst_n   = 1'b0;
        frame_start = first_q;
        shift_row_d = '0;
        oe_n        = ~valid_q;
        if (led_clk) begin
          state_d   = SHIFT;
          col_cnt_d = '0;
        end
      end
      ALIGN: begin
        oe_n = ~valid_q;
        if (led_clk) begin
          state_d   = SHIFT;
          col_cnt_d = '0;
        end
      end
      SHIFT: begin
        oe_n    = ~valid_q;
        al_re_n = ~(col_cnt_q < CNT_W'(COLS));
        if (led_clk) begin
          col_cnt_d = col_cnt_q + 1'b1;
          if (cols_done) state_d = LATCH;
        end
      end
      LATCH: begin
        lat         = 1'b1;
        row_d       = shift_row_q;
        valid_d     = 1'b1;
        blank_cnt_d = '0;
        state_d     = BLANK;
      end
      BLANK: begin
        blank_cnt_d = blank_cnt_q + 3'd1;
        if (blank_last) begin
          if (!enable) begin
            state_d = IDLE;
          end else if (shift_row_q == ROW_W'(ROWS - 1)) begin
            shift_row_d = '0;
            pwm_d       = (pwm_q == 8'(PWM_MAX)) ? 8'd0 : pwm_q + 8'd1;
            state_d     = RRST;
          end else begin
            shift_row_d = shift_row_q + 1'b1;
            state_d     = ALIGN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pwm_value = pwm_q;
  assign row_addr  = row_q;
  assign proto_err = proto_q;

endmodule
